game_sound_sequencer: RTL and testbench

GAME_SOUND_SEQUENCER -- requirements
Module: game_sound_sequencer

---
 rtl/game_sound_sequencer.sv | 88 ++++++++
 tb/tb_game_sound_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/game_sound_sequencer.sv
// game_sound_sequencer: plays fixed WIN/LOSE/SCORED/HIT melodies on rising-edge triggers, timed by frame ticks.
module game_sound_sequencer #(
  parameter int NOTE_FRAMES = 12,
  parameter int HIT_FRAMES = 4
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       winPulse,
  input  logic       losePulse,
  input  logic       scoredPulse,
  input  logic       collisionPulse,
  output logic [3:0] tone,
  output logic       sound_en,
  output logic       busy,
  output logic [1:0] melody_id,
  output logic       done
);
  localparam logic [5:0] NOTE_DUR = 6'(NOTE_FRAMES);
  localparam logic [5:0] LONG_DUR = 6'(2 * NOTE_FRAMES);
  localparam logic [5:0] HIT_DUR = 6'(HIT_FRAMES);
  typedef enum logic [1:0] {S_IDLE, S_NOTE, S_GAP} state_t;
  state_t state, nextState;
  logic [1:0] melody, nextMelody, noteIdx, nextNoteIdx, trigId, lastIdx;
  logic [5:0] frameCnt, nextFrameCnt, noteDur;
  logic [3:0] inputs, prevIn, rise, noteTone;
  logic accept, nextDone, endOfNote;
  // bit position doubles as melody id and priority rank
  assign inputs = {losePulse, winPulse, scoredPulse, collisionPulse};
  assign rise = inputs & ~prevIn;
  assign trigId = rise[3] ? 2'd3 : rise[2] ? 2'd2 : rise[1] ? 2'd1 : 2'd0;
  assign accept = |rise && (state == S_IDLE || trigId >= melody);
  assign noteTone = melody == 2'd3 ? (noteIdx == 2'd0 ? 4'd7 : noteIdx == 2'd1 ? 4'd5 : 4'd3)
                  : melody == 2'd2 ? (noteIdx == 2'd0 ? 4'd8 : noteIdx == 2'd1 ? 4'd10 : noteIdx == 2'd2 ? 4'd12 : 4'd15)
                  : melody == 2'd1 ? (noteIdx == 2'd0 ? 4'd10 : 4'd13) : 4'd6;
  assign noteDur = melody == 2'd3 ? LONG_DUR : melody == 2'd0 ? HIT_DUR : NOTE_DUR;
  assign lastIdx = melody == 2'd3 ? 2'd2 : melody == 2'd2 ? 2'd3 : melody == 2'd1 ? 2'd1 : 2'd0;
  assign endOfNote = startOfFrame && state == S_NOTE && frameCnt == noteDur - 6'd1;
  always_comb begin
    nextState = state;
    nextMelody = melody;
    nextNoteIdx = noteIdx;
    nextFrameCnt = frameCnt;
    nextDone = 1'b0;
    if (accept) begin
      nextState = S_NOTE;
      nextMelody = trigId;
      nextNoteIdx = 2'd0;
      nextFrameCnt = 6'd0;
    end else if (startOfFrame && state == S_GAP) begin
      nextState = S_NOTE;
      nextNoteIdx = noteIdx + 2'd1;
      nextFrameCnt = 6'd0;
    end else if (endOfNote && noteIdx == lastIdx) begin
      nextState = S_IDLE;
      nextMelody = 2'd0;
      nextNoteIdx = 2'd0;
      nextFrameCnt = 6'd0;
      nextDone = 1'b1;
    end else if (endOfNote) begin
      nextState = S_GAP;
      nextFrameCnt = 6'd0;
    end else if (startOfFrame && state == S_NOTE) begin
      nextFrameCnt = frameCnt + 6'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state <= S_IDLE;
      melody <= 2'd0;
      noteIdx <= 2'd0;
      frameCnt <= 6'd0;
      prevIn <= 4'd0;
      done <= 1'b0;
    end else begin
      state <= nextState;
      melody <= nextMelody;
      noteIdx <= nextNoteIdx;
      frameCnt <= nextFrameCnt;
      prevIn <= inputs;
      done <= nextDone;
    end
  end
  assign busy = state != S_IDLE;
  assign sound_en = state == S_NOTE;
  assign tone = busy ? noteTone : 4'd0;
  assign melody_id = busy ? melody : 2'd0;
endmodule

// File: tb/tb_game_sound_sequencer.sv
// tb_game_sound_sequencer: directed scenarios plus random stimulus against a tick-count timeline model.
module tb_game_sound_sequencer;
  localparam int NF = 12;
  localparam int HF = 4;
  localparam int TONES [4][4] = '{'{6, 0, 0, 0}, '{10, 13, 0, 0}, '{8, 10, 12, 15}, '{7, 5, 3, 0}};
  localparam int NOTES [4] = '{1, 2, 4, 3};
  logic clk = 1'b0, resetN = 1'b0, startOfFrame = 1'b0;
  logic winPulse = 1'b0, losePulse = 1'b0, scoredPulse = 1'b0, collisionPulse = 1'b0;
  logic [3:0] tone;
  logic sound_en, busy, done;
  logic [1:0] melody_id;
  int checks = 0, errors = 0, sofCnt = 0;
  bit armed = 1'b0;
  bit mAct = 1'b0, mDone = 1'b0;
  int mMel = 0, mTicks = 0;
  logic [3:0] prev = 4'd0;

  game_sound_sequencer #(.NOTE_FRAMES(NF), .HIT_FRAMES(HF)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .winPulse(winPulse),
    .losePulse(losePulse), .scoredPulse(scoredPulse), .collisionPulse(collisionPulse),
    .tone(tone), .sound_en(sound_en), .busy(busy), .melody_id(melody_id), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int dur(input int m);
    return m == 3 ? 2 * NF : m == 0 ? HF : NF;
  endfunction

  // Model: a melody is a timeline of frame ticks; note j sounds for D ticks, then one gap tick.
  always @(posedge clk) begin
    logic [3:0] r;
    int tid;
    if (!resetN) begin
      mAct = 1'b0; mMel = 0; mTicks = 0; mDone = 1'b0; prev = 4'd0;
    end else begin
      r = {losePulse, winPulse, scoredPulse, collisionPulse} & ~prev;
      prev = {losePulse, winPulse, scoredPulse, collisionPulse};
      tid = r[3] ? 3 : r[2] ? 2 : r[1] ? 1 : 0;
      mDone = 1'b0;
      if (r != 4'd0 && (!mAct || tid >= mMel)) begin
        mAct = 1'b1; mMel = tid; mTicks = 0;
      end else if (mAct && startOfFrame) begin
        mTicks++;
        if (mTicks == NOTES[mMel] * (dur(mMel) + 1) - 1) begin
          mAct = 1'b0; mMel = 0; mTicks = 0; mDone = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    int d, j, r;
    logic [8:0] exp, act;
    if (armed) begin
      exp = {4'd0, 1'b0, 1'b0, 2'd0, mDone};
      if (mAct) begin
        d = dur(mMel); j = mTicks / (d + 1); r = mTicks % (d + 1);
        exp = {4'(TONES[mMel][j]), r < d, 1'b1, 2'(mMel), 1'b0};
      end
      act = {tone, sound_en, busy, melody_id, done};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL model t=%0t {tone,en,busy,id,done} got %b expected %b", $time, act, exp);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input bit w, input bit l, input bit sc, input bit c, input bit f = 1'b0);
    @(posedge clk);
    #2;
    sofCnt++;
    winPulse = w; losePulse = l; scoredPulse = sc; collisionPulse = c;
    startOfFrame = f || (sofCnt % 4 == 0);
  endtask

  task automatic waitIdle(input string name);
    for (int i = 0; i < 600 && busy !== 1'b0; i++) begin
      step(0, 0, 0, 0);
      @(negedge clk);
    end
    chk(name, busy, 0);
  endtask

  initial begin
    int n10, n13, n8, doneCnt, ticks, notLose;
    step(0, 0, 0, 0);
    armed = 1'b1;
    step(0, 0, 0, 0);
    @(negedge clk);
    chk("reset_tone", tone, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    step(0, 0, 0, 0);
    resetN = 1'b1;
    // scored melody: 12 ticks of each note, then a single done
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    @(negedge clk);
    chk("scored_tone0", tone, 10);
    chk("scored_id", melody_id, 1);
    chk("scored_en", sound_en, 1);
    n10 = 0; n13 = 0; doneCnt = 0;
    for (int i = 0; i < 400 && busy === 1'b1; i++) begin
      n10 += int'(tone == 10 && sound_en && startOfFrame);
      n13 += int'(tone == 13 && sound_en && startOfFrame);
      step(0, 0, 0, 0);
      @(negedge clk);
      doneCnt += int'(done);
    end
    chk("scored_n10", n10, 12);
    chk("scored_n13", n13, 12);
    chk("scored_done", doneCnt, 1);
    chk("scored_end_busy", busy, 0);
    // win held for 300 frames plays once
    n8 = 0; doneCnt = 0;
    for (int i = 0; i < 1200; i++) begin
      step(1, 0, 0, 0);
      @(negedge clk);
      n8 += int'(tone == 8 && sound_en && startOfFrame);
      doneCnt += int'(done);
    end
    chk("win_hold_n8", n8, 12);
    chk("win_hold_done", doneCnt, 1);
    step(0, 0, 0, 0);
    // lose aborts win on note 2
    step(1, 0, 0, 0);
    for (int i = 0; i < 600 && !(tone == 12 && sound_en); i++) begin
      step(1, 0, 0, 0);
      @(negedge clk);
    end
    chk("win_note2", tone, 12);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    @(negedge clk);
    chk("abort_tone", tone, 7);
    chk("abort_id", melody_id, 3);
    chk("abort_done", done, 0);
    // collision during lose is discarded; lose runs 3 x 24 frames
    ticks = 0; notLose = 0; doneCnt = 0;
    for (int i = 0; i < 600 && busy === 1'b1; i++) begin
      ticks += int'(startOfFrame);
      notLose += int'(melody_id != 2'd3);
      step(1, 1, 0, i == 20);
      @(negedge clk);
      doneCnt += int'(done);
    end
    chk("lose_ticks", ticks, 74);
    chk("lose_id_held", notLose, 0);
    chk("lose_done", doneCnt, 1);
    step(0, 0, 0, 0);
    // coinciding triggers on a frame tick
    step(0, 0, 1, 1, 1);
    step(0, 0, 0, 0);
    @(negedge clk);
    chk("coinc_tone", tone, 10);
    chk("coinc_id", melody_id, 1);
    waitIdle("coinc_end_busy");
    // reset during HIT with win high at release
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    @(negedge clk);
    chk("hit_tone", tone, 6);
    step(1, 0, 0, 0);
    resetN = 1'b0;
    step(1, 0, 0, 0);
    resetN = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_tone", tone, 0);
    chk("rst_mid_done", done, 0);
    step(1, 0, 0, 0);
    @(negedge clk);
    chk("rst_win_tone", tone, 8);
    chk("rst_win_id", melody_id, 2);
    // random phase
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      #2;
      resetN = $urandom_range(0, 299) != 0;
      if ($urandom_range(0, 199) == 0) winPulse = ~winPulse;
      if ($urandom_range(0, 299) == 0) losePulse = ~losePulse;
      scoredPulse = $urandom_range(0, 59) == 0;
      collisionPulse = $urandom_range(0, 19) == 0;
      startOfFrame = $urandom_range(0, 2) == 0;
    end
    step(0, 0, 0, 0);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
